// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger/countdown interface.
package trigger_pkg;

   localparam int unsigned CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_EARLY   = 2'd1,
      ST_LATE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_e;

endpackage

// File: rtl/trigger_fifo.sv
// Request FIFO for the trigger scheduler; flags and level are registered.
module trigger_fifo
   import trigger_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_wr,
   input  logic [CNT_W-1:0]         i_wr_data,
   input  logic                     i_rd,
   output logic [CNT_W-1:0]         o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [CNT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level_nxt;
   logic             wr_acc;
   logic             rd_acc;

   always_comb begin
      wr_acc    = i_wr && !o_full;
      rd_acc    = i_rd && !o_empty;
      level_nxt = o_level + LW'(wr_acc) - LW'(rd_acc);
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_level <= '0;
         o_full  <= 1'b0;
         o_empty <= 1'b1;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         o_level <= level_nxt;
         o_full  <= (level_nxt == LW'(DEPTH));
         o_empty <= (level_nxt == '0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_acc) mem[wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = mem[rd_ptr];

endmodule

// File: rtl/trigger_scheduler.sv
// Issues queued delay requests to a countdown block and grades the
// arrival time of each completion pulse.
module trigger_scheduler
   import trigger_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned SLACK = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  logic [CNT_W-1:0]       i_req_cnt,
   output logic                   o_trg,
   output logic [CNT_W-1:0]       o_cnt,
   input  logic                   i_pulse,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [1:0]             o_status,
   output logic                   o_stray,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int unsigned WW = CNT_W + 1;

   state_e           state;
   state_e           state_nxt;
   status_e          status_q;
   status_e          status_nxt;
   logic [CNT_W-1:0] cur;
   logic [CNT_W-1:0] cur_nxt;
   logic [WW-1:0]    w;
   logic [WW-1:0]    w_nxt;
   logic [WW-1:0]    wc;
   logic [WW-1:0]    limit;
   logic [CNT_W-1:0] fifo_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_rd;
   logic             wr_acc;

   trigger_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr      (i_req_valid),
      .i_wr_data (i_req_cnt),
      .i_rd      (fifo_rd),
      .o_rd_data (fifo_data),
      .o_full    (fifo_full),
      .o_empty   (fifo_empty),
      .o_level   (o_level)
   );

   assign o_req_ready = !fifo_full;
   assign wr_acc      = i_req_valid && !fifo_full;
   assign o_status    = status_q;

   // Next-state and result grading; wc is the WAIT-cycle index (first WAIT cycle = 1).
   always_comb begin
      state_nxt  = state;
      status_nxt = status_q;
      cur_nxt    = cur;
      w_nxt      = w;
      fifo_rd    = 1'b0;
      wc         = w + WW'(1);
      limit      = WW'(cur) + WW'(SLACK);

      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_rd = 1'b1;
               cur_nxt = fifo_data;
               if (fifo_data != '0) begin
                  state_nxt = S_ISSUE;
               end else begin
                  state_nxt  = S_DONE;
                  status_nxt = ST_OK;
               end
            end
         end
         S_ISSUE: begin
            w_nxt     = '0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            w_nxt = wc;
            if (i_pulse) begin
               state_nxt = S_DONE;
               if (wc < WW'(cur))       status_nxt = ST_EARLY;
               else if (wc == WW'(cur)) status_nxt = ST_OK;
               else                     status_nxt = ST_LATE;
            end else if (wc == limit) begin
               state_nxt  = S_DONE;
               status_nxt = ST_TIMEOUT;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         status_q <= ST_OK;
         cur      <= '0;
         w        <= '0;
         o_trg    <= 1'b0;
         o_cnt    <= '0;
         o_done   <= 1'b0;
         o_stray  <= 1'b0;
         o_busy   <= 1'b0;
      end else begin
         state    <= state_nxt;
         status_q <= status_nxt;
         cur      <= cur_nxt;
         w        <= w_nxt;
         o_trg    <= (state_nxt == S_ISSUE);
         if (state_nxt == S_ISSUE) o_cnt <= cur_nxt;
         o_done   <= (state_nxt == S_DONE);
         o_stray  <= i_pulse && (state != S_WAIT);
         // A pop only happens when leaving IDLE, so staying in IDLE implies no pop.
         o_busy   <= (state_nxt != S_IDLE) || wr_acc || !fifo_empty;
      end
   end

endmodule
